// File: rtl/pifo_pkg.sv
// pifo_pkg: shared definitions for the PIFO minimum scheduler.
//   - FSM state encoding (IDLE / REDUCE / DONE)
//   - levels_for(): number of pairwise-min passes needed for n entries
//   - entry_t: (rank, slot index, valid) record at the default widths
package pifo_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REDUCE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_IDX_WIDTH  = 3;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_IDX_WIDTH-1:0]  idx;
    logic                      valid;
  } entry_t;

  function automatic int levels_for(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/pifo_min_stage.sv
// pifo_min_stage: one combinational pairwise-min pass.
//   in_*  : N elements (rank, slot index, valid)
//   out_* : N/2 elements, out[j] = min(in[2j], in[2j+1])
// Both valid: smaller rank wins, equal ranks keep the lower position.
// One valid: that one wins. Neither valid: out_valid=0.
module pifo_min_stage #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 16,
  parameter int IDX_WIDTH  = 3
) (
  input  logic [N-1:0][DATA_WIDTH-1:0]   in_data,
  input  logic [N-1:0][IDX_WIDTH-1:0]    in_idx,
  input  logic [N-1:0]                   in_valid,
  output logic [N/2-1:0][DATA_WIDTH-1:0] out_data,
  output logic [N/2-1:0][IDX_WIDTH-1:0]  out_idx,
  output logic [N/2-1:0]                 out_valid
);

  always_comb begin
    out_data  = '0;
    out_idx   = '0;
    out_valid = '0;
    for (int j = 0; j < N/2; j++) begin
      // Upper element only wins when it is strictly better; ties stay low.
      if (in_valid[2*j+1] && (!in_valid[2*j] || (in_data[2*j+1] < in_data[2*j]))) begin
        out_data[j] = in_data[2*j+1];
        out_idx[j]  = in_idx[2*j+1];
      end else begin
        out_data[j] = in_data[2*j];
        out_idx[j]  = in_idx[2*j];
      end
      out_valid[j] = in_valid[2*j] | in_valid[2*j+1];
    end
  end

endmodule

// File: rtl/pifo_min_sched.sv
// pifo_min_sched: register-based PIFO that returns the minimum-rank entry.
//   axis_aclk / axis_resetn : clock, async active-low reset
//   ins_valid/ins_ready/ins_data : insert a rank into the lowest free slot
//   rem_valid/rem_ready          : start a minimum search
//   res_valid/res_data/res_idx/res_empty : one-cycle result strobe
//   count / full / empty          : occupancy
//
// state  | meaning
// IDLE   | accepting inserts and removes
// REDUCE | stage vector halved once per cycle, LEVELS cycles
// DONE   | result strobe; winner slot freed on exit
module pifo_min_sched
  import pifo_pkg::*;
#(
  parameter int REG_WIDTH  = 8,
  parameter int IDX_WIDTH  = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_resetn,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  input  logic [DATA_WIDTH-1:0] ins_data,
  input  logic                  rem_valid,
  output logic                  rem_ready,
  output logic                  res_valid,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic [IDX_WIDTH-1:0]  res_idx,
  output logic                  res_empty,
  output logic [IDX_WIDTH:0]    count,
  output logic                  full,
  output logic                  empty
);

  localparam int LEVELS = levels_for(REG_WIDTH);

  logic [1:0]                           state_q;
  logic [IDX_WIDTH-1:0]                 lvl_cnt;
  logic [REG_WIDTH-1:0][DATA_WIDTH-1:0] ent_data;
  logic [REG_WIDTH-1:0]                 ent_valid;
  logic [IDX_WIDTH:0]                   count_q;

  logic [REG_WIDTH-1:0][DATA_WIDTH-1:0]   st_data;
  logic [REG_WIDTH-1:0][IDX_WIDTH-1:0]    st_idx;
  logic [REG_WIDTH-1:0]                   st_valid;
  logic [REG_WIDTH/2-1:0][DATA_WIDTH-1:0] min_data;
  logic [REG_WIDTH/2-1:0][IDX_WIDTH-1:0]  min_idx;
  logic [REG_WIDTH/2-1:0]                 min_valid;

  logic [IDX_WIDTH-1:0] free_idx;
  logic                 ins_fire;
  logic                 rem_fire;
  logic                 last_level;

  assign count      = count_q;
  assign full       = (count_q == (IDX_WIDTH+1)'(REG_WIDTH));
  assign empty      = (count_q == '0);
  assign ins_ready  = (state_q == ST_IDLE) && !full;
  assign rem_ready  = (state_q == ST_IDLE);
  assign ins_fire   = ins_valid && ins_ready;
  assign rem_fire   = rem_valid && rem_ready;
  assign last_level = (lvl_cnt == IDX_WIDTH'(LEVELS-1));

  // Lowest-index free slot; only meaningful when not full.
  always_comb begin
    free_idx = '0;
    for (int i = REG_WIDTH-1; i >= 0; i--) begin
      if (!ent_valid[i]) free_idx = IDX_WIDTH'(i);
    end
  end

  pifo_min_stage #(
    .N          (REG_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_stage (
    .in_data   (st_data),
    .in_idx    (st_idx),
    .in_valid  (st_valid),
    .out_data  (min_data),
    .out_idx   (min_idx),
    .out_valid (min_valid)
  );

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q   <= ST_IDLE;
      lvl_cnt   <= '0;
      st_data   <= '0;
      st_idx    <= '0;
      st_valid  <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
      res_empty <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rem_fire) begin
            // Snapshot excludes a same-edge insert (ent_* not yet updated).
            st_data  <= ent_data;
            st_valid <= ent_valid;
            for (int i = 0; i < REG_WIDTH; i++) st_idx[i] <= IDX_WIDTH'(i);
            lvl_cnt  <= '0;
            state_q  <= ST_REDUCE;
          end
        end
        ST_REDUCE: begin
          st_data[REG_WIDTH/2-1:0]          <= min_data;
          st_idx[REG_WIDTH/2-1:0]           <= min_idx;
          st_valid[REG_WIDTH/2-1:0]         <= min_valid;
          st_data[REG_WIDTH-1:REG_WIDTH/2]  <= '0;
          st_idx[REG_WIDTH-1:REG_WIDTH/2]   <= '0;
          st_valid[REG_WIDTH-1:REG_WIDTH/2] <= '0;
          lvl_cnt <= lvl_cnt + 1'b1;
          if (last_level) begin
            // Result registers hold after the strobe until the next search.
            res_valid <= 1'b1;
            res_data  <= min_data[0];
            res_idx   <= min_idx[0];
            res_empty <= !min_valid[0];
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          res_valid <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: begin
          res_valid <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // Inserts only happen in IDLE and frees only on DONE exit, so the
  // count never moves both ways on the same edge.
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      ent_data  <= '0;
      ent_valid <= '0;
      count_q   <= '0;
    end else begin
      if (ins_fire) begin
        ent_data[free_idx]  <= ins_data;
        ent_valid[free_idx] <= 1'b1;
        count_q             <= count_q + 1'b1;
      end else if ((state_q == ST_DONE) && !res_empty) begin
        ent_valid[res_idx] <= 1'b0;
        count_q            <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pifo_min_sched.sv
module tb_pifo_min_sched;
  import pifo_pkg::*;

  localparam int REG_WIDTH  = 8;
  localparam int IDX_WIDTH  = 3;
  localparam int DATA_WIDTH = 16;
  localparam int LEVELS     = 3;

  logic                  axis_aclk = 1'b0;
  logic                  axis_resetn = 1'b0;
  logic                  ins_valid = 1'b0;
  logic                  ins_ready;
  logic [DATA_WIDTH-1:0] ins_data = '0;
  logic                  rem_valid = 1'b0;
  logic                  rem_ready;
  logic                  res_valid;
  logic [DATA_WIDTH-1:0] res_data;
  logic [IDX_WIDTH-1:0]  res_idx;
  logic                  res_empty;
  logic [IDX_WIDTH:0]    count;
  logic                  full;
  logic                  empty;

  pifo_min_sched #(
    .REG_WIDTH  (REG_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) dut (
    .axis_aclk   (axis_aclk),
    .axis_resetn (axis_resetn),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .rem_valid   (rem_valid),
    .rem_ready   (rem_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_idx     (res_idx),
    .res_empty   (res_empty),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 axis_aclk = ~axis_aclk;

  int checks = 0;
  int failures = 0;

  // Reference model: entry array, occupancy, busy countdown and scoreboard.
  logic [DATA_WIDTH-1:0] m_data[REG_WIDTH];
  bit                    m_valid[REG_WIDTH];
  int                    m_count = 0;
  int                    busy = 0;
  int                    win_slot = -1;
  int                    cyc = 0;
  int                    acc_cyc = 0;
  int                    prev_acc = 0;
  bit                    pending = 0;
  bit                    spacing_on = 0;
  bit                    have_prev = 0;
  entry_t                sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < REG_WIDTH; i++) begin
      m_valid[i] = 0;
      m_data[i]  = '0;
    end
    m_count = 0; busy = 0; win_slot = -1; pending = 0; have_prev = 0;
    sb.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_idx",   32'(res_idx),   32'd0);
    chk("rst_res_empty", 32'(res_empty), 32'd0);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_empty",     32'(empty),     32'd1);
    chk("rst_full",      32'(full),      32'd0);
    chk("rst_ins_ready", 32'(ins_ready), 32'd1);
    chk("rst_rem_ready", 32'(rem_ready), 32'd1);
  endtask

  // Asserted #1 after a clock edge, so it can land mid-search.
  task automatic do_reset();
    ins_valid = 1'b0;
    rem_valid = 1'b0;
    axis_resetn = 1'b0;
    #1;
    model_clear();
    chk_reset_outputs();
    repeat (2) @(posedge axis_aclk);
    #1;
    chk_reset_outputs();
    axis_resetn = 1'b1;
  endtask

  // One clock: predict handshakes from the model, advance, then check.
  task automatic tick();
    bit     ins_f, rem_f, exp_rv;
    int     fs, w;
    entry_t e;
    chk("rem_ready", 32'(rem_ready), 32'(busy == 0));
    chk("ins_ready", 32'(ins_ready), 32'((busy == 0) && (m_count < REG_WIDTH)));
    ins_f = (busy == 0) && (m_count < REG_WIDTH) && ins_valid;
    rem_f = (busy == 0) && rem_valid;
    fs = -1;
    w  = -1;
    for (int i = 0; i < REG_WIDTH; i++) begin
      if (!m_valid[i] && fs < 0) fs = i;
      if (m_valid[i] && (w < 0 || m_data[i] < m_data[w])) w = i;
    end
    if (busy > 0) begin
      busy--;
      if (busy == 0 && win_slot >= 0) begin
        m_valid[win_slot] = 0;
        m_count--;
      end
    end else if (rem_f) begin
      if (spacing_on && have_prev) chk("accept_spacing", 32'(cyc + 1 - prev_acc), 32'(LEVELS + 2));
      prev_acc  = cyc + 1;
      have_prev = 1;
      e.valid = (w >= 0);
      e.data  = (w >= 0) ? m_data[w] : '0;
      e.idx   = (w >= 0) ? IDX_WIDTH'(w) : '0;
      sb.push_back(e);
      win_slot = w;
      pending  = 1;
      acc_cyc  = cyc + 1;
      busy     = LEVELS + 1;
    end
    if (ins_f) begin
      m_valid[fs] = 1;
      m_data[fs]  = ins_data;
      m_count++;
    end
    @(posedge axis_aclk);
    #1;
    cyc++;
    exp_rv = pending && (cyc == acc_cyc + LEVELS);
    chk("res_valid", 32'(res_valid), 32'(exp_rv));
    if (exp_rv && sb.size() > 0) begin
      e = sb.pop_front();
      pending = 0;
      chk("res_empty", 32'(res_empty), 32'(!e.valid));
      if (e.valid) begin
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("res_idx",  32'(res_idx),  32'(e.idx));
      end
    end
    chk("count", 32'(count), 32'(m_count));
    chk("full",  32'(full),  32'(m_count == REG_WIDTH));
    chk("empty", 32'(empty), 32'(m_count == 0));
  endtask

  task automatic ins_one(input logic [DATA_WIDTH-1:0] d);
    ins_valid = 1'b1;
    ins_data  = d;
    tick();
    ins_valid = 1'b0;
  endtask

  task automatic remove_one();
    rem_valid = 1'b1;
    tick();
    rem_valid = 1'b0;
    repeat (LEVELS + 1) tick();
  endtask

  initial begin
    // Reset, then remove from empty: res_empty strobe, count stays 0.
    do_reset();
    remove_one();
    chk("empty_after_rm", 32'(empty), 32'd1);

    // Tie order by slot index; result registers hold after the strobe.
    ins_one(16'd50); ins_one(16'd20); ins_one(16'd70); ins_one(16'd20);
    remove_one();
    chk("hold_data", 32'(res_data), 32'd20);
    chk("hold_idx",  32'(res_idx),  32'd1);
    remove_one();
    chk("hold_idx2", 32'(res_idx), 32'd3);
    remove_one();
    chk("hold_data3", 32'(res_data), 32'd50);

    // Fill with 8..1; a held 9th insert lands in the freed slot 7.
    do_reset();
    for (int i = 0; i < REG_WIDTH; i++) ins_one(DATA_WIDTH'(REG_WIDTH - i));
    chk("full_after_fill", 32'(full), 32'd1);
    ins_valid = 1'b1;
    ins_data  = 16'd99;
    tick();
    rem_valid = 1'b1;
    tick();
    rem_valid = 1'b0;
    repeat (LEVELS + 2) tick();
    ins_valid = 1'b0;
    repeat (REG_WIDTH) remove_one();
    chk("last_idx_slot7", 32'(res_idx), 32'd7);

    // Same-edge insert and remove.
    do_reset();
    ins_one(16'd30); ins_one(16'd10);
    ins_valid = 1'b1; ins_data = 16'd5; rem_valid = 1'b1;
    tick();
    ins_valid = 1'b0; rem_valid = 1'b0;
    repeat (LEVELS + 1) tick();
    chk("count_after_same_edge", 32'(count), 32'd2);
    remove_one();

    // Back-to-back removes with rem_valid held high.
    spacing_on = 1;
    have_prev  = 0;
    rem_valid  = 1'b1;
    repeat (3 * (LEVELS + 2)) tick();
    rem_valid  = 1'b0;
    repeat (2) tick();
    spacing_on = 0;

    // Reset in the middle of a search: no strobe, everything lost.
    ins_one(16'd7); ins_one(16'd3); ins_one(16'd9);
    rem_valid = 1'b1;
    tick();
    rem_valid = 1'b0;
    tick();
    do_reset();
    repeat (6) tick();
    remove_one();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
